fifo_rd_sched: RTL and testbench
================================

# fifo_rd_sched

Read-side scheduler for the asynchronous FIFO in the read clock domain. It decides when to pop the FIFO and holds popped words in a 2-entry output buffer. Words go to a downstream consumer, such as the UART TX framer, over a valid/ready handshake. It enforces the pop spacing that the registered Gray read pointer and empty flag require, and adds an optional programmable gap between pops for slow consumers.

## Interface
Parameters:
- DATA_WIDTH, 8, FIFO word width
- GAP_W, 4, width of the inter-pop gap setting

Ports:
- i_r_clk  in  1  read-domain clock
- i_rst_n  in  1  reset, asynchronous, active-low; clock i_r_clk
- i_en  in  1  scheduler enable; 0 blocks new pops
- i_gap  in  GAP_W  extra idle cycles inserted after each pop (0..2^GAP_W-1)
- i_r_empty  in  1  FIFO empty flag from FIFO read-pointer logic
- i_rd_data  in  DATA_WIDTH  FIFO head word, combinational read of current read address
- o_r_inc  out  1  FIFO pop strobe, one cycle wide
- o_valid  out  1  output buffer holds at least one word
- o_data  out  DATA_WIDTH  oldest buffered word
- i_ready  in  1  consumer accepts o_data when o_valid & i_ready
- o_busy  out  1  state != IDLE or o_valid
- o_word_cnt  out  16  words delivered to consumer (see Configuration)

## Operation
- FSM states: IDLE, SETTLE, GAP.
  - IDLE -> SETTLE when pop condition is true; o_r_inc=1 in that cycle.
  - SETTLE lasts exactly 1 cycle, then goes to GAP if i_gap!=0, else to IDLE.
  - GAP counts i_gap cycles (i_gap sampled on SETTLE entry), then goes to IDLE.
- Pop condition (IDLE only): i_en & ~i_r_empty & (buf_cnt < 2).
- o_r_inc is combinational from registered state/count and i_r_empty; it is high only in IDLE.
- On the pop cycle, i_rd_data is written into the output buffer at the clock edge ending that cycle.
- Output buffer: 2-entry FIFO with registered storage, buf_cnt in 0..2.
  - o_valid = (buf_cnt != 0); o_data = head entry.
  - Consumer take: o_valid & i_ready.
  - Simultaneous push and take in one cycle: buf_cnt unchanged, order preserved.
  - A take in the pop cycle does not make room for that pop; the buf_cnt<2 check uses the registered count.
- i_en deassert:
  - no new pop is issued from IDLE;
  - SETTLE/GAP in progress runs to completion;
  - buffered words still drain.
- i_gap changes mid-GAP do not affect the current gap.

## Timing
- Reset values:
  - state=IDLE, buf_cnt=0, gap counter=0;
  - o_r_inc=0, o_valid=0, o_data=0, o_busy=0, o_word_cnt=0.
- Reset mid-operation discards buffered words immediately. The FIFO pointers are reset by the same i_rst_n.
- Pop spacing:
  - A pop in cycle k updates the binary read pointer at end of k and the Gray pointer at end of k+1.
  - i_r_empty is therefore trustworthy in cycle k+2, so the earliest next pop is k+2 (i_gap=0), or k+2+i_gap in general.
- Peak throughput is 1 word per 2 cycles.
- Latency: a word popped in cycle k is on o_data with o_valid=1 in cycle k+1.
- Empty boundary: with one word in the FIFO, exactly one pop occurs. No second pop is issued while i_r_empty is stale.
- Buffer full (buf_cnt=2): the scheduler stays in IDLE with o_r_inc=0 until a take lowers buf_cnt.
- o_word_cnt wraps from 16'hFFFF to 0.

## Configuration
- Macro RD_SCHED_CNT_EN.
- Defined:
  - o_word_cnt increments by 1 on each consumer take (o_valid & i_ready);
  - it resets to 0 and wraps modulo 2^16.
- Undefined:
  - counter logic is not compiled;
  - o_word_cnt is tied to 16'h0000;
  - all other behaviour is identical.

## Test plan
- Reset, then write 0xA5 into the FIFO, with i_en=1, i_gap=0, i_ready=1:
  - one o_r_inc pulse;
  - o_valid=1 with o_data=0xA5 one cycle later;
  - no further o_r_inc.
- Preload 4 words 0x01..0x04, i_gap=0, i_ready=1:
  - o_r_inc pulses spaced exactly 2 cycles apart;
  - words delivered in order 0x01..0x04;
  - o_word_cnt=4 with the macro, 0 without.
- Preload 4 words, i_gap=3:
  - o_r_inc pulses spaced 5 cycles apart;
  - i_gap changed to 0 mid-GAP does not shorten the current gap.
- Preload 5 words, i_ready=0:
  - exactly 2 pops, then buf_cnt=2 and o_r_inc held 0;
  - raising i_ready drains 0x01, 0x02 first, then pops resume;
  - all 5 are delivered in order.
- Preload 3 words; drop i_en during SETTLE after the first pop:
  - SETTLE completes and no new pop occurs;
  - word 1 is still delivered;
  - re-asserting i_en resumes pops of words 2 and 3.
- Assert i_rst_n=0 asynchronously while buf_cnt=2 and state=GAP:
  - immediately o_valid=0, o_r_inc=0, o_busy=0, o_word_cnt=0;
  - after release, state is IDLE.

Source files
------------

// File: rtl/fifo_rd_sched.sv
// fifo_rd_sched: read-domain pop scheduler for the async FIFO.
// Pops are spaced so the registered Gray read pointer and empty flag have
// settled before the next pop decision. An optional inter-pop gap is added
// for slow consumers. Popped words sit in a 2-entry output buffer.
// Optional feature macro: RD_SCHED_CNT_EN (delivered-word counter on o_word_cnt).
module fifo_rd_sched #(
  parameter int DATA_WIDTH = 8,
  parameter int GAP_W      = 4
) (
  input  logic                  i_r_clk,
  input  logic                  i_rst_n,
  input  logic                  i_en,
  input  logic [GAP_W-1:0]      i_gap,
  input  logic                  i_r_empty,
  input  logic [DATA_WIDTH-1:0] i_rd_data,
  output logic                  o_r_inc,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data,
  input  logic                  i_ready,
  output logic                  o_busy,
  output logic [15:0]           o_word_cnt
);

  typedef enum logic [1:0] {IDLE, SETTLE, GAP} state_t;

  state_t                state;
  logic [GAP_W-1:0]      gap_cnt;
  logic [DATA_WIDTH-1:0] obuf [2];
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic [1:0]            buf_cnt;
  logic                  pop;
  logic                  take;

  // Pop decision uses the registered count only: a same-cycle take does not
  // free a slot for this pop.
  assign pop     = (state == IDLE) & i_en & ~i_r_empty & ~buf_cnt[1];
  assign take    = o_valid & i_ready;
  assign o_r_inc = pop;
  assign o_valid = (buf_cnt != 2'd0);
  assign o_data  = obuf[rd_ptr];
  assign o_busy  = (state != IDLE) | o_valid;

  // Scheduler FSM: IDLE -> SETTLE (one cycle for the Gray pointer/empty flag)
  // -> optional GAP of i_gap cycles, captured at the pop edge.
  always_ff @(posedge i_r_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= IDLE;
      gap_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            state   <= SETTLE;
            gap_cnt <= i_gap;
          end
        end
        SETTLE: begin
          state <= (gap_cnt != '0) ? GAP : IDLE;
        end
        GAP: begin
          if (gap_cnt == GAP_W'(1)) state <= IDLE;
          gap_cnt <= gap_cnt - GAP_W'(1);
        end
        default: begin
          state   <= IDLE;
          gap_cnt <= '0;
        end
      endcase
    end
  end

  // Output buffer: 2-entry ring; push on pop, drain on consumer take.
  always_ff @(posedge i_r_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      obuf[0] <= '0;
      obuf[1] <= '0;
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      buf_cnt <= 2'd0;
    end else begin
      if (pop) begin
        obuf[wr_ptr] <= i_rd_data;
        wr_ptr       <= ~wr_ptr;
      end
      if (take) rd_ptr <= ~rd_ptr;
      case ({pop, take})
        2'b10:   buf_cnt <= buf_cnt + 2'd1;
        2'b01:   buf_cnt <= buf_cnt - 2'd1;
        default: buf_cnt <= buf_cnt;
      endcase
    end
  end

`ifdef RD_SCHED_CNT_EN
  logic [15:0] word_cnt;

  // Delivered-word counter, wraps modulo 2^16.
  always_ff @(posedge i_r_clk or negedge i_rst_n) begin
    if (!i_rst_n) word_cnt <= 16'h0000;
    else if (take) word_cnt <= word_cnt + 16'd1;
  end

  assign o_word_cnt = word_cnt;
`else
  assign o_word_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_fifo_rd_sched.sv
// tb_fifo_rd_sched: directed + randomized bench for fifo_rd_sched.
// The FIFO is modelled with a one-cycle-late read pointer feeding empty, so
// the flag is stale in the cycle after a pop. The reference model tracks the
// scheduler as "cycles since last pop vs 2+gap" plus a word queue.
module tb_fifo_rd_sched;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [3:0]  gap = 4'd0;
  logic        empty;
  logic [7:0]  rd_data;
  logic        r_inc;
  logic        valid;
  logic [7:0]  data;
  logic        ready = 1'b0;
  logic        busy;
  logic [15:0] word_cnt;

  fifo_rd_sched #(.DATA_WIDTH(8), .GAP_W(4)) dut (
    .i_r_clk   (clk),
    .i_rst_n   (rst_n),
    .i_en      (en),
    .i_gap     (gap),
    .i_r_empty (empty),
    .i_rd_data (rd_data),
    .o_r_inc   (r_inc),
    .o_valid   (valid),
    .o_data    (data),
    .i_ready   (ready),
    .o_busy    (busy),
    .o_word_cnt(word_cnt)
  );

  always #5 clk = ~clk;

  // FIFO environment: memory, write pointer (driven by tasks), read pointer
  // and its one-cycle-late copy that drives the empty flag.
  logic [7:0] fifo_mem [256];
  logic [7:0] wptr   = 8'd0;
  logic [7:0] rptr   = 8'd0;
  logic [7:0] rptr_g = 8'd0;

  assign empty   = (rptr_g == wptr);
  assign rd_data = fifo_mem[rptr];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rptr   <= 8'd0;
      rptr_g <= 8'd0;
    end else begin
      if (r_inc) rptr <= rptr + 8'd1;
      rptr_g <= rptr;
    end
  end

  // Reference model state
  int         cyc = 0;
  int         last_pop = -1000;
  int         last_gap = 0;
  logic [7:0] m_rd = 8'd0;
  logic [7:0] m_buf [$];
  int         m_cnt = 0;

  // Per-cycle observed / expected values
  logic        obs_inc, obs_valid, obs_busy;
  logic [7:0]  obs_data;
  logic [15:0] obs_wc;
  logic        exp_inc, exp_valid, exp_busy;
  logic [7:0]  exp_data;
  logic [15:0] exp_wc;

  int vectors = 0;
  int errs = 0;

  task automatic write_word(input logic [7:0] v);
    fifo_mem[wptr] = v;
    wptr = wptr + 8'd1;
  endtask

  function automatic logic [15:0] model_wc();
`ifdef RD_SCHED_CNT_EN
    return 16'(m_cnt);
`else
    return 16'h0000;
`endif
  endfunction

  // Advance one clock: sample DUT and predict, then update the model at the edge.
  task automatic cyc_step();
    logic       m_idle;
    logic [7:0] occ;
    #1;
    obs_inc   = r_inc;
    obs_valid = valid;
    obs_data  = data;
    obs_busy  = busy;
    obs_wc    = word_cnt;
    occ       = wptr - m_rd;
    m_idle    = (cyc - last_pop) >= (2 + last_gap);
    exp_valid = (m_buf.size() != 0);
    exp_inc   = m_idle && en && (occ != 8'd0) && (m_buf.size() < 2);
    exp_data  = exp_valid ? m_buf[0] : 8'h00;
    exp_busy  = !m_idle || exp_valid;
    exp_wc    = model_wc();
    @(posedge clk);
    if (exp_valid && ready) begin
      void'(m_buf.pop_front());
      m_cnt++;
    end
    if (exp_inc) begin
      m_buf.push_back(fifo_mem[m_rd]);
      m_rd     = m_rd + 8'd1;
      last_pop = cyc;
      last_gap = int'(gap);
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic model_reset();
    last_pop = -1000;
    last_gap = 0;
    m_rd     = 8'd0;
    m_buf.delete();
    m_cnt    = 0;
    wptr     = 8'd0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    vectors++;
    if ({r_inc, valid, busy, data, word_cnt} !== 27'd0) begin
      errs++;
      $display("FAIL reset_vals got inc=%b valid=%b busy=%b data=%h cnt=%h exp all 0",
               r_inc, valid, busy, data, word_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single_word();
    int pulses = 0;
    en = 1'b1; gap = 4'd0; ready = 1'b1;
    write_word(8'hA5);
    for (int i = 0; i < 8; i++) begin
      cyc_step();
      if (obs_inc) pulses++;
      vectors++;
      if ({obs_inc, obs_valid, obs_busy} !== {exp_inc, exp_valid, exp_busy}) begin
        errs++;
        $display("FAIL single_ctl cyc=%0d inc/valid/busy got %b%b%b exp %b%b%b",
                 cyc, obs_inc, obs_valid, obs_busy, exp_inc, exp_valid, exp_busy);
      end
      if (exp_valid) begin
        vectors++;
        if (obs_data !== exp_data) begin
          errs++;
          $display("FAIL single_data cyc=%0d got %h exp %h", cyc, obs_data, exp_data);
        end
      end
    end
    vectors++;
    if (pulses != 1) begin
      errs++;
      $display("FAIL single_pulses got %0d exp 1", pulses);
    end
  endtask

  task automatic test_back_to_back();
    int pulses = 0;
    int lp = -1;
    en = 1'b1; gap = 4'd0; ready = 1'b1;
    for (int w = 1; w <= 4; w++) write_word(8'(w));
    for (int i = 0; i < 14; i++) begin
      cyc_step();
      if (obs_inc) begin
        pulses++;
        if (lp >= 0) begin
          vectors++;
          if (cyc - lp != 2) begin
            errs++;
            $display("FAIL b2b_spacing got %0d exp 2", cyc - lp);
          end
        end
        lp = cyc;
      end
      vectors++;
      if ({obs_inc, obs_valid, obs_busy} !== {exp_inc, exp_valid, exp_busy}) begin
        errs++;
        $display("FAIL b2b_ctl cyc=%0d inc/valid/busy got %b%b%b exp %b%b%b",
                 cyc, obs_inc, obs_valid, obs_busy, exp_inc, exp_valid, exp_busy);
      end
      if (exp_valid) begin
        vectors++;
        if (obs_data !== exp_data) begin
          errs++;
          $display("FAIL b2b_data cyc=%0d got %h exp %h", cyc, obs_data, exp_data);
        end
      end
    end
    vectors++;
    if (pulses != 4) begin
      errs++;
      $display("FAIL b2b_pulses got %0d exp 4", pulses);
    end
    vectors++;
    if (obs_wc !== exp_wc) begin
      errs++;
      $display("FAIL b2b_wordcnt got %0d exp %0d", obs_wc, exp_wc);
    end
  endtask

  task automatic test_gap();
    int pulses = 0;
    int lp = -100;
    en = 1'b1; ready = 1'b1;
    for (int w = 1; w <= 4; w++) write_word(8'(16 + w));
    for (int i = 0; i < 26; i++) begin
      // Drop i_gap to 0 in the middle of each GAP window; it must not shorten it
      gap = ((cyc - lp == 2) || (cyc - lp == 3)) ? 4'd0 : 4'd3;
      cyc_step();
      if (obs_inc) begin
        pulses++;
        if (lp >= 0) begin
          vectors++;
          if (cyc - lp != 5) begin
            errs++;
            $display("FAIL gap_spacing got %0d exp 5", cyc - lp);
          end
        end
        lp = cyc;
      end
      vectors++;
      if ({obs_inc, obs_valid, obs_busy} !== {exp_inc, exp_valid, exp_busy}) begin
        errs++;
        $display("FAIL gap_ctl cyc=%0d inc/valid/busy got %b%b%b exp %b%b%b",
                 cyc, obs_inc, obs_valid, obs_busy, exp_inc, exp_valid, exp_busy);
      end
      if (exp_valid) begin
        vectors++;
        if (obs_data !== exp_data) begin
          errs++;
          $display("FAIL gap_data cyc=%0d got %h exp %h", cyc, obs_data, exp_data);
        end
      end
    end
    vectors++;
    if (pulses != 4) begin
      errs++;
      $display("FAIL gap_pulses got %0d exp 4", pulses);
    end
    gap = 4'd0;
  endtask

  task automatic test_full();
    int         pulses = 0;
    logic [7:0] got [$];
    en = 1'b1; gap = 4'd0; ready = 1'b0;
    for (int w = 1; w <= 5; w++) write_word(8'(w));
    for (int i = 0; i < 10; i++) begin
      cyc_step();
      if (obs_inc) pulses++;
      vectors++;
      if ({obs_inc, obs_valid, obs_busy} !== {exp_inc, exp_valid, exp_busy}) begin
        errs++;
        $display("FAIL full_ctl cyc=%0d inc/valid/busy got %b%b%b exp %b%b%b",
                 cyc, obs_inc, obs_valid, obs_busy, exp_inc, exp_valid, exp_busy);
      end
    end
    vectors++;
    if (pulses != 2) begin
      errs++;
      $display("FAIL full_pops got %0d exp 2", pulses);
    end
    ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      cyc_step();
      if (obs_valid && ready) got.push_back(obs_data);
      vectors++;
      if ({obs_inc, obs_valid, obs_busy} !== {exp_inc, exp_valid, exp_busy}) begin
        errs++;
        $display("FAIL full_drain_ctl cyc=%0d inc/valid/busy got %b%b%b exp %b%b%b",
                 cyc, obs_inc, obs_valid, obs_busy, exp_inc, exp_valid, exp_busy);
      end
    end
    vectors++;
    if (got.size() != 5) begin
      errs++;
      $display("FAIL full_count got %0d exp 5", got.size());
    end
    for (int i = 0; i < got.size() && i < 5; i++) begin
      vectors++;
      if (got[i] !== 8'(i + 1)) begin
        errs++;
        $display("FAIL full_order idx=%0d got %h exp %h", i, got[i], 8'(i + 1));
      end
    end
  endtask

  task automatic test_en_drop();
    int pulses = 0;
    int budget = 0;
    en = 1'b1; gap = 4'd0; ready = 1'b1;
    for (int w = 1; w <= 3; w++) write_word(8'(32 + w));
    do begin
      cyc_step();
      budget++;
    end while (!obs_inc && budget < 20);
    vectors++;
    if (!obs_inc) begin
      errs++;
      $display("FAIL endrop_first_pop got no pop within %0d cycles exp a pop", budget);
    end
    en = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cyc_step();
      if (obs_inc) pulses++;
      vectors++;
      if ({obs_inc, obs_valid, obs_busy} !== {exp_inc, exp_valid, exp_busy}) begin
        errs++;
        $display("FAIL endrop_ctl cyc=%0d inc/valid/busy got %b%b%b exp %b%b%b",
                 cyc, obs_inc, obs_valid, obs_busy, exp_inc, exp_valid, exp_busy);
      end
      if (exp_valid) begin
        vectors++;
        if (obs_data !== exp_data) begin
          errs++;
          $display("FAIL endrop_data cyc=%0d got %h exp %h", cyc, obs_data, exp_data);
        end
      end
    end
    vectors++;
    if (pulses != 0) begin
      errs++;
      $display("FAIL endrop_no_pop got %0d pops exp 0", pulses);
    end
    en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cyc_step();
      if (obs_inc) pulses++;
      vectors++;
      if ({obs_inc, obs_valid, obs_busy} !== {exp_inc, exp_valid, exp_busy}) begin
        errs++;
        $display("FAIL enresume_ctl cyc=%0d inc/valid/busy got %b%b%b exp %b%b%b",
                 cyc, obs_inc, obs_valid, obs_busy, exp_inc, exp_valid, exp_busy);
      end
      if (exp_valid) begin
        vectors++;
        if (obs_data !== exp_data) begin
          errs++;
          $display("FAIL enresume_data cyc=%0d got %h exp %h", cyc, obs_data, exp_data);
        end
      end
    end
    vectors++;
    if (pulses != 2) begin
      errs++;
      $display("FAIL enresume_pops got %0d exp 2", pulses);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      en    = ($urandom_range(0, 7) != 0);
      ready = ($urandom_range(0, 2) != 0);
      gap   = 4'($urandom_range(0, 3));
      if ((wptr - m_rd) < 8'd6 && $urandom_range(0, 1) == 1) write_word(8'($urandom));
      cyc_step();
      vectors++;
      if ({obs_inc, obs_valid, obs_busy} !== {exp_inc, exp_valid, exp_busy}) begin
        errs++;
        $display("FAIL rand_ctl cyc=%0d inc/valid/busy got %b%b%b exp %b%b%b",
                 cyc, obs_inc, obs_valid, obs_busy, exp_inc, exp_valid, exp_busy);
      end
      if (exp_valid) begin
        vectors++;
        if (obs_data !== exp_data) begin
          errs++;
          $display("FAIL rand_data cyc=%0d got %h exp %h", cyc, obs_data, exp_data);
        end
      end
      vectors++;
      if (obs_wc !== exp_wc) begin
        errs++;
        $display("FAIL rand_wordcnt cyc=%0d got %0d exp %0d", cyc, obs_wc, exp_wc);
      end
    end
  endtask

  task automatic test_async_reset();
    int pulses = 0;
    int budget = 0;
    en = 1'b1; gap = 4'd5; ready = 1'b0;
    for (int w = 1; w <= 5; w++) write_word(8'(64 + w));
    while (pulses < 2 && budget < 40) begin
      cyc_step();
      if (obs_inc) pulses++;
      budget++;
    end
    vectors++;
    if (pulses != 2) begin
      errs++;
      $display("FAIL arst_setup got %0d pops exp 2", pulses);
    end
    // Now in SETTLE; one more cycle puts the scheduler in GAP with buf_cnt=2
    cyc_step();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    vectors++;
    if ({r_inc, valid, busy, word_cnt} !== 19'd0) begin
      errs++;
      $display("FAIL arst_immediate got inc=%b valid=%b busy=%b cnt=%h exp all 0",
               r_inc, valid, busy, word_cnt);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    gap = 4'd0; ready = 1'b1;
    cyc_step();
    vectors++;
    if ({obs_inc, obs_valid, obs_busy} !== 3'b000) begin
      errs++;
      $display("FAIL arst_release inc/valid/busy got %b%b%b exp 000",
               obs_inc, obs_valid, obs_busy);
    end
    // An idle scheduler pops on the very first cycle a word is available
    write_word(8'h5A);
    cyc_step();
    vectors++;
    if (obs_inc !== 1'b1 || exp_inc !== 1'b1) begin
      errs++;
      $display("FAIL arst_idle_pop got inc=%b exp 1", obs_inc);
    end
    cyc_step();
    vectors++;
    if (obs_valid !== 1'b1 || obs_data !== 8'h5A) begin
      errs++;
      $display("FAIL arst_idle_data got valid=%b data=%h exp 1/5a", obs_valid, obs_data);
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_gap();
    test_full();
    test_en_drop();
    test_random();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
